// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered valid/ready stream demultiplexer. Each input beat carries a
//   lane select. Beats are buffered in a 2-entry in-order FIFO and presented
//   on the selected output lane. The head entry's payload is shared by all
//   lanes. Beats whose select is out of range are consumed and dropped, and
//   each drop bumps a saturating counter.
//
//   No combinational path runs from any input to the data/valid outputs.
//   ready_o is derived only from the registered occupancy and from rst_i.
//
// Ports
//   clk_i      : clock; all state updates on the rising edge
//   rst_i      : synchronous reset, active-high
//   sel_i      : destination lane of the current input beat
//   data_i     : input payload
//   valid_i    : input beat valid
//   ready_o    : block can accept a beat
//   data_o     : payload of the head entry (shared by all lanes)
//   valid_o    : one-hot lane valid, all zero when the buffer is empty
//   ready_i    : per-lane downstream ready
//   drop_cnt_o : saturating count of beats dropped for an out-of-range select
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int NUM_ELEM   = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [$clog2(NUM_ELEM)-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic [NUM_ELEM-1:0]         valid_o,
    input  logic [NUM_ELEM-1:0]         ready_i,
    output logic [CNT_WIDTH-1:0]        drop_cnt_o
);

    localparam int SEL_W = $clog2(NUM_ELEM);

    // Storage and control state
    logic [SEL_W-1:0]      r_sel  [2];
    logic [DATA_WIDTH-1:0] r_data [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [SEL_W-1:0]      w_head_sel;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign ready_o    = !rst_i && (r_count != 2'd2);
    assign w_accept   = valid_i && ready_o;
    // Only reachable when NUM_ELEM is not a power of two.
    assign w_in_range = (32'(sel_i) < NUM_ELEM);
    assign w_push     = w_accept && w_in_range;
    assign w_drop     = w_accept && !w_in_range;

    assign w_head_sel = r_sel[r_rptr];
    // Only the head entry's own lane can retire it; other lanes' ready is ignored.
    assign w_pop      = (r_count != 2'd0) && ready_i[w_head_sel];

    assign data_o     = r_data[r_rptr];
    assign drop_cnt_o = r_drop_cnt;

    always_comb begin
        valid_o = '0;
        if (r_count != 2'd0) begin
            valid_o[w_head_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_drop_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_sel[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_sel[r_wptr]  <= sel_i;
                r_data[r_wptr] <= data_i;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
            // A dropped beat never touches occupancy; only push/pop do.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic [7:0] data;
    logic       vld;
    logic [6:0] rdy;

    logic       ready_o_a, ready_o_b;
    logic [7:0] data_o_a,  data_o_b;
    logic [6:0] valid_o_a, valid_o_b;
    logic [7:0] drop_a;
    logic [1:0] drop_b;

    always #5 clk = ~clk;

    stream_demux #(.NUM_ELEM(7), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .data_i(data), .valid_i(vld),
        .ready_o(ready_o_a), .data_o(data_o_a), .valid_o(valid_o_a),
        .ready_i(rdy), .drop_cnt_o(drop_a)
    );

    // Narrow-counter instance shares the stimulus; used for saturation.
    stream_demux #(.NUM_ELEM(7), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .data_i(data), .valid_i(vld),
        .ready_o(ready_o_b), .data_o(data_o_b), .valid_o(valid_o_b),
        .ready_i(rdy), .drop_cnt_o(drop_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an in-order queue of beats plus a plain drop tally.
    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
    } beat_t;
    beat_t q[$];
    int    drops = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] sel;
        logic [7:0] data;
        logic [6:0] rdy;
        logic       exp_rdy;
        logic [6:0] exp_vld;
        logic       chk_data;
        logic [7:0] exp_data;
        int         exp_drop;
    } vec_t;
    vec_t tv[13];

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit can_acc;
        bit do_pop;
        if (rst) begin
            q.delete();
            drops = 0;
        end else begin
            can_acc = (q.size() != 2);
            do_pop  = (q.size() > 0) && rdy[q[0].sel];
            if (do_pop) void'(q.pop_front());
            if (vld && can_acc) begin
                if (sel < 3'd7) q.push_back('{sel: sel, data: data});
                else            drops++;
            end
        end
    endtask

    // Drive inputs, clock once, update the model, sample 1 time unit later.
    task automatic apply(input logic r, input logic v, input logic [2:0] s,
                         input logic [7:0] d, input logic [6:0] rd);
        rst = r; vld = v; sel = s; data = d; rdy = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [6:0] ev;
        ev = (q.size() > 0) ? (7'd1 << q[0].sel) : 7'd0;
        chk({tag, ".ready"}, 32'(ready_o_a), 32'(!rst && q.size() != 2));
        chk({tag, ".valid"}, 32'(valid_o_a), 32'(ev));
        if (q.size() > 0) chk({tag, ".data"}, 32'(data_o_a), 32'(q[0].data));
        chk({tag, ".drop"}, 32'(drop_a), sat(drops, 255));
        chk({tag, ".drop_sat"}, 32'(drop_b), sat(drops, 3));
    endtask

    initial begin
        // rst vld sel data rdy | exp_rdy exp_vld chk_data exp_data exp_drop
        tv[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 7'h00, 1'b0, 7'b0000000, 1'b1, 8'h00, 0};
        tv[1]  = '{1'b0, 1'b1, 3'd0, 8'h11, 7'h7F, 1'b1, 7'b0000001, 1'b1, 8'h11, 0};
        tv[2]  = '{1'b0, 1'b1, 3'd3, 8'h22, 7'h7F, 1'b1, 7'b0001000, 1'b1, 8'h22, 0};
        tv[3]  = '{1'b0, 1'b1, 3'd6, 8'h33, 7'h7F, 1'b1, 7'b1000000, 1'b1, 8'h33, 0};
        tv[4]  = '{1'b0, 1'b1, 3'd1, 8'h44, 7'h7F, 1'b1, 7'b0000010, 1'b1, 8'h44, 0};
        tv[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'b0000000, 1'b0, 8'h00, 0};
        tv[6]  = '{1'b0, 1'b1, 3'd2, 8'hA0, 7'h00, 1'b1, 7'b0000100, 1'b1, 8'hA0, 0};
        tv[7]  = '{1'b0, 1'b1, 3'd5, 8'hA1, 7'h00, 1'b0, 7'b0000100, 1'b1, 8'hA0, 0};
        tv[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 7'h20, 1'b0, 7'b0000100, 1'b1, 8'hA0, 0};
        tv[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 7'h04, 1'b1, 7'b0100000, 1'b1, 8'hA1, 0};
        tv[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 7'h00, 1'b1, 7'b0100000, 1'b1, 8'hA1, 0};
        tv[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 7'h20, 1'b1, 7'b0000000, 1'b0, 8'h00, 0};
        tv[12] = '{1'b0, 1'b1, 3'd7, 8'h55, 7'h00, 1'b1, 7'b0000000, 1'b0, 8'h00, 1};

        for (int i = 0; i < 13; i++) begin
            apply(tv[i].rst, tv[i].vld, tv[i].sel, tv[i].data, tv[i].rdy);
            chk($sformatf("tv%0d.ready", i), 32'(ready_o_a), 32'(tv[i].exp_rdy));
            chk($sformatf("tv%0d.valid", i), 32'(valid_o_a), 32'(tv[i].exp_vld));
            if (tv[i].chk_data)
                chk($sformatf("tv%0d.data", i), 32'(data_o_a), 32'(tv[i].exp_data));
            chk($sformatf("tv%0d.drop", i), 32'(drop_a), tv[i].exp_drop);
            chk($sformatf("tv%0d.drop_sat", i), 32'(drop_b), sat(tv[i].exp_drop, 3));
        end

        // Drop while a beat is buffered: head stays put, counter saturates.
        apply(1'b0, 1'b1, 3'd1, 8'hBB, 7'h00);
        check_model("hold");
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 3'd7, 8'(i), 7'h00);
            check_model("drop");
            chk("drop.valid_kept", 32'(valid_o_a), 32'h02);
        end
        chk("drop.sat3", 32'(drop_b), 32'd3);
        chk("drop.wide5", 32'(drop_a), 32'd5);
        apply(1'b0, 1'b0, 3'd0, 8'h00, 7'h02);
        check_model("drain");

        // Steady state: push and pop every cycle, no bubbles.
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 3'(i % 7), 8'(8'h40 + i), 7'h7F);
            check_model("steady");
            chk("steady.ready", 32'(ready_o_a), 32'd1);
            chk("steady.data", 32'(data_o_a), 32'(8'h40 + i));
        end
        apply(1'b0, 1'b0, 3'd0, 8'h00, 7'h7F);
        check_model("steady_end");

        // Reset with the buffer full.
        apply(1'b0, 1'b1, 3'd0, 8'hC0, 7'h00);
        apply(1'b0, 1'b1, 3'd3, 8'hC1, 7'h00);
        chk("full.ready", 32'(ready_o_a), 32'd0);
        apply(1'b1, 1'b0, 3'd0, 8'h00, 7'h00);
        chk("rst.ready", 32'(ready_o_a), 32'd0);
        chk("rst.valid", 32'(valid_o_a), 32'd0);
        apply(1'b0, 1'b0, 3'd0, 8'h00, 7'h00);
        chk("post_rst.ready", 32'(ready_o_a), 32'd1);
        chk("post_rst.valid", 32'(valid_o_a), 32'd0);
        chk("post_rst.drop", 32'(drop_a), 32'd0);
        apply(1'b0, 1'b1, 3'd4, 8'h5A, 7'h00);
        chk("post_rst.lane4", 32'(valid_o_a), 32'h10);
        chk("post_rst.data", 32'(data_o_a), 32'h5A);
        check_model("post_rst");

        // Random traffic against the queue model.
        for (int c = 0; c < 10000; c++) begin
            logic       r;
            logic [6:0] rd;
            r  = ($urandom_range(0, 999) == 0);
            rd = 7'($urandom);
            if ($urandom_range(0, 3) == 0) rd = 7'h7F;
            apply(r, ($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), rd);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
